// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared UART baud divisor defaults, OSR helper and divisor struct
// Revision : 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DIV_W  = 16;
  localparam int UART_FRAC_W = 4;
  localparam int UART_OSR    = 16;

  function automatic int osr_w(input int osr);
    return $clog2(osr);
  endfunction

  typedef struct packed {
    logic [UART_DIV_W-1:0]  div_int;
    logic [UART_FRAC_W-1:0] div_frac;
  } baud_div_t;

endpackage
`default_nettype wire

// File: rtl/baud_frac_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// baud_frac_acc : fractional divisor accumulator, carry stretches one period
// Revision      : 1.0
// ---------------------------------------------------------------------------
module baud_frac_acc
  import uart_pkg::*;
#(
  parameter int FRAC_W = UART_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              reload,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              carry
);

  logic [FRAC_W-1:0] frac_acc;
  logic [FRAC_W:0]   sum;

  // Carry is valid combinationally in the reload cycle and picks that period's length.
  assign sum   = {1'b0, frac_acc} + {1'b0, div_frac};
  assign carry = sum[FRAC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frac_acc <= '0;
    end else if (clear) begin
      frac_acc <= '0;
    end else if (reload) begin
      frac_acc <= sum[FRAC_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_baud_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_baud_tick_gen : programmable oversample / bit / mid-bit tick generator
//                      fractional divisor enabled by defining BAUD_FRAC_EN
// Revision           : 1.0
// ---------------------------------------------------------------------------
module uart_baud_tick_gen
  import uart_pkg::*;
#(
  parameter int DIV_W  = UART_DIV_W,
  parameter int FRAC_W = UART_FRAC_W,
  parameter int OSR    = UART_OSR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              count_en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              mid_tick
);

  localparam int               OSR_W   = osr_w(OSR);
  localparam logic [OSR_W-1:0] OS_LAST = OSR_W'(OSR - 1);
  localparam logic [OSR_W-1:0] OS_MID  = OSR_W'(OSR / 2 - 1);

  logic [DIV_W:0]   cnt;
  logic [OSR_W-1:0] os_cnt;
  logic             first;
  logic             active;
  logic             wrap;
  logic             carry;
  logic [DIV_W:0]   reload_val;

  // Ticks decode pre-increment os_cnt; restart and the load cycle never tick.
  assign active   = count_en && !restart && !first;
  assign wrap     = active && (cnt == '0);
  assign os_tick  = wrap;
  assign bit_tick = wrap && (os_cnt == OS_LAST);
  assign mid_tick = wrap && (os_cnt == OS_MID);

`ifdef BAUD_FRAC_EN
  baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (restart),
    .reload   (wrap),
    .div_frac (div_frac),
    .carry    (carry)
  );
`else
  logic unused_div_frac;
  assign unused_div_frac = ^div_frac;
  assign carry           = 1'b0;
`endif

  assign reload_val = {1'b0, div_int} + {{DIV_W{1'b0}}, carry};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      os_cnt <= '0;
      first  <= 1'b1;
    end else if (restart) begin
      cnt    <= {1'b0, div_int};
      os_cnt <= '0;
      first  <= 1'b0;
    end else if (count_en) begin
      if (first) begin
        cnt   <= {1'b0, div_int};
        first <= 1'b0;
      end else if (cnt == '0) begin
        cnt    <= reload_val;
        os_cnt <= os_cnt + OSR_W'(1);
      end else begin
        cnt <= cnt - (DIV_W + 1)'(1);
      end
    end
  end

endmodule
`default_nettype wire
